// File: rtl/rf_pkg.sv
// Shared constants and address-legality helper for the multi-port register file.
// Latency: n/a (package). Backpressure: n/a.
// Contents: default widths/depth, rf_legal() used by storage and scoreboard alike.
package rf_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_NUM_REGS = 32;

    // An address is writable/markable when it maps to an implemented register
    // and is not the hardwired-zero register.
    function automatic logic rf_legal(
        input int unsigned addr,
        input logic        is_zero_reg_enabled,
        input int unsigned num_regs = RF_NUM_REGS
    );
        return (addr < num_regs) && !(is_zero_reg_enabled && (addr == 0));
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: issue marks pending, writeback clears; popcount and sticky out-of-range flag.
// Latency: busy/busy_cnt/wr_oor update on the posedge after the request. Backpressure: none, always accepts.
// Ports: clk, rst_n, wr_en/wr_addr, iss_en/iss_addr in; busy vector, busy_cnt, wr_oor out.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int CNT_W    = $clog2(NUM_REGS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_addr,
    output logic [NUM_REGS-1:0] busy,
    output logic [CNT_W-1:0]    busy_cnt,
    output logic                wr_oor
);

    logic                wr_ok;
    logic                iss_ok;
    logic                oor_hit;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [CNT_W-1:0]    cnt_nxt;

    assign wr_ok   = wr_en  && rf_legal(32'(wr_addr),  ZERO_REG != 0, NUM_REGS);
    assign iss_ok  = iss_en && rf_legal(32'(iss_addr), ZERO_REG != 0, NUM_REGS);
    assign oor_hit = (wr_en  && !rf_legal(32'(wr_addr),  1'b0, NUM_REGS)) ||
                     (iss_en && !rf_legal(32'(iss_addr), 1'b0, NUM_REGS));

    // Clear from writeback first, then set from issue, so a same-cycle
    // issue to the register being written back leaves it pending.
    always_comb begin
        busy_nxt = busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (wr_ok && (wr_addr == ADDR_W'(r)))
                busy_nxt[r] = 1'b0;
            if (iss_ok && (iss_addr == ADDR_W'(r)))
                busy_nxt[r] = 1'b1;
        end
    end

    // Count is recomputed from the next vector so it can never drift from it.
    always_comb begin
        cnt_nxt = '0;
        for (int r = 0; r < NUM_REGS; r++)
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[r]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= '0;
            busy_cnt <= '0;
            wr_oor   <= 1'b0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
            if (oor_hit)
                wr_oor <= 1'b1;
        end
    end

endmodule

// File: rtl/register_file_mp.sv
// Multi-read-port register file with one synchronous write port, optional zero register and write bypass.
// Latency: reads combinational (zero cycles); writes visible next cycle, or same cycle with bypass. Backpressure: none.
// Ports: rd_addr/rd_data/rd_busy (NUM_RD packed ports), wr_en/wr_addr/wr_data, iss_en/iss_addr, busy_cnt, wr_oor.
module register_file_mp
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]         rd_addr,
    output logic [NUM_RD*DATA_W-1:0]         rd_data,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_addr,
    input  logic [DATA_W-1:0]                wr_data,
    input  logic                             iss_en,
    input  logic [ADDR_W-1:0]                iss_addr,
    output logic [$clog2(NUM_REGS+1)-1:0]    busy_cnt,
    output logic                             wr_oor
);

    if (NUM_REGS < 2 || NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("register_file_mp: NUM_REGS must lie in 2..2**ADDR_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
        $error("register_file_mp: NUM_RD must lie in 1..4");
    end

    logic [DATA_W-1:0]   mem [NUM_REGS];
    logic [NUM_REGS-1:0] busy;
    logic                wr_ok;

    assign wr_ok = wr_en && rf_legal(32'(wr_addr), ZERO_REG != 0, NUM_REGS);

    // Register 0 is never written when ZERO_REG is set, so it stays at its reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NUM_REGS; r++)
                mem[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++)
                if (wr_ok && (wr_addr == ADDR_W'(r)))
                    mem[r] <= wr_data;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .busy     (busy),
        .busy_cnt (busy_cnt),
        .wr_oor   (wr_oor)
    );

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] raddr;
        logic [DATA_W-1:0] rdata;
        logic              rbusy;

        assign raddr = rd_addr[p*ADDR_W +: ADDR_W];

        // Out-of-range addresses match no register and fall through as 0/not busy.
        // A bypass hit returns the in-flight value and reports not busy, since
        // the producer is completing this very cycle.
        always_comb begin
            rdata = '0;
            rbusy = 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                if (raddr == ADDR_W'(r)) begin
                    rdata = mem[r];
                    rbusy = busy[r];
                end
            end
            if ((ZERO_REG != 0) && (raddr == '0)) begin
                rdata = '0;
                rbusy = 1'b0;
            end
            if ((BYPASS != 0) && wr_ok && (wr_addr == raddr)) begin
                rdata = wr_data;
                rbusy = 1'b0;
            end
        end

        assign rd_data[p*DATA_W +: DATA_W] = rdata;
        assign rd_busy[p]                  = rbusy;
    end

endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
- Parametrised, clocked successor to the combinational register file.
- Provides NUM_RD asynchronous read ports and one synchronous write port.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register busy scoreboard: the issue stage marks a destination pending and writeback clears it, so the decode stage can detect RAW hazards.
- Sits between decode (reads, issue) and writeback (write) in the RISC core.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width.
- NUM_REGS, 32, implemented registers. Must satisfy 2 <= NUM_REGS <= 2**ADDR_W; elaboration error otherwise.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, is never busy.
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- rd_addr  input  NUM_RD*ADDR_W  read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  output  NUM_RD*DATA_W  read data, packed the same way as rd_addr.
- rd_busy  output  NUM_RD  per-port pending flag for the addressed register.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- iss_en  input  1  mark a destination register pending.
- iss_addr  input  ADDR_W  destination register to mark.
- busy_cnt  output  $clog2(NUM_REGS+1)  number of registers currently busy.
- wr_oor  output  1  sticky flag: a write or issue targeted an out-of-range address.

Behaviour:
- Reset (rst_n low, asynchronous) clears:
  - all registers to 0
  - all busy bits to 0
  - busy_cnt to 0
  - wr_oor to 0
- rd_data and rd_busy are combinational, so during reset they read 0.
- Write:
  - At posedge clk with wr_en=1 and wr_addr<NUM_REGS, mem[wr_addr] <= wr_data.
  - Ignored when ZERO_REG=1 and wr_addr==0.
  - One write per cycle; there are no write-write collisions.
- Read, per port i, combinational, zero latency:
  - rd_addr>=NUM_REGS -> rd_data=0, rd_busy=0.
  - ZERO_REG=1 and rd_addr==0 -> rd_data=0, rd_busy=0.
  - Bypass hit (BYPASS=1, wr_en=1, wr_addr==rd_addr, write is legal) -> rd_data=wr_data, rd_busy=0.
  - Otherwise rd_data=mem[rd_addr] and rd_busy=busy[rd_addr].
  - With BYPASS=0, the written value is visible from the cycle after the write edge.
- Scoreboard, updated at posedge clk:
  - iss_en=1 with a legal address -> busy[iss_addr] <= 1.
  - wr_en=1 with a legal address -> busy[wr_addr] <= 0.
  - iss_en and wr_en to the same address in the same cycle -> busy stays/becomes 1; the new issue wins.
  - iss_en to an already-busy register -> stays 1, no double count.
  - wr_en to a non-busy register -> plain write, busy_cnt unchanged.
  - Register 0 with ZERO_REG=1 -> never marked busy.
- busy_cnt:
  - Registered; always equals popcount(busy).
  - Per cycle it changes by -1, 0 or +1. Same-address iss+wr gives net 0 if already busy, +1 if not.
  - Never exceeds NUM_REGS - ZERO_REG.
- wr_oor:
  - Set at posedge when wr_en or iss_en is 1 and the corresponding address >= NUM_REGS.
  - Holds until reset; no other clear.
  - An out-of-range write/issue has no other effect.
- Reset mid-operation: state clears immediately on rst_n falling. The first legal write is taken at the first posedge after rst_n rises.
- No X propagation: every output is defined for every input combination once out of reset.

Decomposition:
- Package rf_pkg holds:
  - default constants RF_DATA_W=32, RF_ADDR_W=5, RF_NUM_REGS=32
  - a function rf_legal(addr, is_zero_reg_enabled) returning whether an address is writable/markable
- Sub-module rf_scoreboard(NUM_REGS, ADDR_W, ZERO_REG) owns the busy vector, busy_cnt and wr_oor.
- register_file_mp keeps the storage array and the read/bypass muxes.

Test Plan:
- Reset then read all addresses on both ports -> rd_data=0, rd_busy=0, busy_cnt=0, wr_oor=0.
- Write 0x0011_1334 to r5, read r5 the same cycle -> BYPASS=1: 0x0011_1334; BYPASS=0: old value 0, then 0x0011_1334 the next cycle.
- Write 0xDEAD_BEEF to r0 -> r0 reads 0. Issue r0 -> busy_cnt stays 0.
- Issue r7, then r9 -> busy_cnt=2 and rd_busy=1 on r7. Write r7 -> busy_cnt=1. Same-cycle issue+write r9 -> r9 stays busy, busy_cnt=1.
- NUM_REGS=20: write address 25 -> no register changes; wr_oor=1 next cycle and stays set until rst_n pulse. Read address 25 -> 0.
- Assert rst_n low mid-sequence with 3 registers busy and data stored -> all outputs 0 immediately; after release, first write lands normally.
